dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 123 ++++++++++++
 tb/tb_dmem_lsu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit for four asynchronous-read byte banks.
// Two-state handshake; misaligned accesses resolve in one bank cycle.
module dmem_lsu #(
   parameter int unsigned BANK_AW = 14
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_i,
   input  logic                     we_i,
   input  logic [1:0]               size_i,
   input  logic                     unsigned_i,
   input  logic [31:0]              addr_i,
   input  logic [31:0]              wdata_i,
   output logic                     ready_o,
   output logic                     rvalid_o,
   output logic [31:0]              rdata_o,
   output logic                     fault_o,
   output logic [3:0]               bank_wren_o,
   output logic [3:0][BANK_AW-1:0]  bank_addr_o,
   output logic [3:0][7:0]          bank_wdata_o,
   input  logic [3:0][7:0]          bank_rdata_i
);

   localparam int unsigned ABW = BANK_AW + 2;
   localparam int unsigned LW  = ABW + 1;

   typedef enum logic {
      IDLE,
      RESP
   } state_e;

   state_e state_q;

   logic               accept;
   logic [2:0]         len;
   logic [1:0]         off;
   logic [LW-1:0]      last;
   logic               fault;
   logic [BANK_AW-1:0] row;
   logic [BANK_AW-1:0] row_nx;
   logic [3:0]         touched;
   logic [3:0][1:0]    kidx;
   logic [1:0]         lane;
   logic [31:0]        lbytes;
   logic [31:0]        ext;
   logic               sx;

   assign ready_o = (state_q == IDLE);
   assign accept  = req_i & ready_o;

   always_comb begin
      unique case (size_i)
         2'b00:   len = 3'd1;
         2'b01:   len = 3'd2;
         2'b10:   len = 3'd4;
         default: len = 3'd1;
      endcase
      off    = addr_i[1:0];
      row    = addr_i[ABW-1:2];
      row_nx = row + BANK_AW'(1);
      // carry out of the top address bit means the access runs off the end
      last   = {1'b0, addr_i[ABW-1:0]} + LW'(len - 3'd1);
      fault  = (size_i == 2'b11) | (|addr_i[31:ABW]) | last[ABW];
   end

   always_comb begin
      touched      = '0;
      kidx         = '0;
      bank_wren_o  = '0;
      bank_addr_o  = '0;
      bank_wdata_o = '0;
      for (int l = 0; l < 4; l++) begin
         kidx[l]         = 2'(l) - off;
         touched[l]      = ({1'b0, kidx[l]} < len);
         bank_addr_o[l]  = (touched[l] && (2'(l) < off)) ? row_nx : row;
         bank_wdata_o[l] = wdata_i[{kidx[l], 3'b000} +: 8];
         bank_wren_o[l]  = rst_ni & accept & we_i & ~fault & touched[l];
      end
   end

   always_comb begin
      lbytes = '0;
      lane   = '0;
      for (int k = 0; k < 4; k++) begin
         lane             = 2'(k) + off;
         lbytes[8*k +: 8] = bank_rdata_i[lane];
      end
      sx = ~unsigned_i;
      unique case (size_i)
         2'b00:   ext = {{24{sx & lbytes[7]}}, lbytes[7:0]};
         2'b01:   ext = {{16{sx & lbytes[15]}}, lbytes[15:0]};
         default: ext = lbytes;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         rvalid_o <= 1'b0;
         fault_o  <= 1'b0;
         rdata_o  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_i) begin
                  state_q  <= RESP;
                  rvalid_o <= 1'b1;
                  fault_o  <= fault;
                  rdata_o  <= (we_i | fault) ? 32'h0 : ext;
               end
            end
            RESP: begin
               state_q  <= IDLE;
               rvalid_o <= 1'b0;
               fault_o  <= 1'b0;
               rdata_o  <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: flat byte-memory model, per-cycle compare,
// directed vectors with literal expectations.
module tb_dmem_lsu;

   logic             clk_i;
   logic             rst_ni;
   logic             req;
   logic             we;
   logic [1:0]       size;
   logic             uns;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic             ready;
   logic             rvalid;
   logic [31:0]      rdata;
   logic             fault;
   logic [3:0]       wren;
   logic [3:0][13:0] baddr;
   logic [3:0][7:0]  bwdata;
   logic [3:0][7:0]  brdata;

   logic [7:0] bank [4][16384];
   logic [7:0] ref_mem [65536];

   int checks = 0;
   int errors = 0;

   logic        m_busy = 1'b0;
   logic [31:0] e_rdata = '0;
   logic        e_fault = 1'b0;
   logic [31:0] last_rdata = '0;
   logic        last_fault = 1'b0;
   logic        rdy_seq [4];

   dmem_lsu #(.BANK_AW(14)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req),
      .we_i         (we),
      .size_i       (size),
      .unsigned_i   (uns),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .ready_o      (ready),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .fault_o      (fault),
      .bank_wren_o  (wren),
      .bank_addr_o  (baddr),
      .bank_wdata_o (bwdata),
      .bank_rdata_i (brdata)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // asynchronous-read banks
   always_comb begin
      brdata = '0;
      for (int l = 0; l < 4; l++) brdata[l] = bank[l][baddr[l]];
   end

   always @(posedge clk_i) begin
      for (int l = 0; l < 4; l++)
         if (wren[l]) bank[l][baddr[l]] = bwdata[l];
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int nlen(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic mfault(input logic [1:0] sz,
                                   input logic [31:0] a);
      longint lst;
      lst = longint'(a) + longint'(nlen(sz)) - 1;
      return (sz == 2'b11) || (a > 32'hFFFF) || (lst > 65535);
   endfunction

   function automatic logic [31:0] mload(input logic [1:0] sz,
                                         input logic u,
                                         input logic [31:0] a);
      logic [31:0] v;
      int n;
      n = nlen(sz);
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(a + k) & 32'hFFFF];
      if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      return v;
   endfunction

   function automatic logic [3:0] mmask(input logic [1:0] sz,
                                        input logic [31:0] a);
      logic [3:0] m;
      m = '0;
      for (int k = 0; k < nlen(sz); k++) m[(a + k) & 3] = 1'b1;
      return m;
   endfunction

   function automatic logic [13:0] mrow(input int l, input logic [1:0] sz,
                                        input logic [31:0] a);
      logic [31:0] r;
      r = a >> 2;
      for (int k = 0; k < nlen(sz); k++)
         if (((a + k) & 3) == l) r = (a + k) >> 2;
      return 14'(r & 32'h3FFF);
   endfunction

   // reference: one access per two cycles, memory as a flat byte array
   always @(posedge clk_i) begin
      if (!rst_ni) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         m_busy = 1'b0;
      end else if (req) begin
         m_busy  = 1'b1;
         e_fault = mfault(size, addr);
         e_rdata = (we || e_fault) ? 32'h0 : mload(size, uns, addr);
         if (we && !e_fault)
            for (int k = 0; k < nlen(size); k++)
               ref_mem[(addr + k) & 32'hFFFF] = wdata[8*k +: 8];
      end
   end

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
         chk("rst_rdata", rdata, 32'h0);
         chk("rst_fault", {31'b0, fault}, 32'h0);
         chk("rst_wren", {28'b0, wren}, 32'h0);
      end else begin
         chk("ready", {31'b0, ready}, {31'b0, !m_busy});
         chk("rvalid", {31'b0, rvalid}, {31'b0, m_busy});
         if (m_busy) begin
            chk("rdata", rdata, e_rdata);
            chk("fault", {31'b0, fault}, {31'b0, e_fault});
            last_rdata = rdata;
            last_fault = fault;
         end
         if (!m_busy && req && we && !mfault(size, addr))
            chk("wren", {28'b0, wren}, {28'b0, mmask(size, addr)});
         else
            chk("wren", {28'b0, wren}, 32'h0);
         if (!m_busy && req && size != 2'b11)
            for (int l = 0; l < 4; l++)
               chk("bank_addr", {18'b0, baddr[l]}, {18'b0, mrow(l, size, addr)});
      end
   end

   // called at posedge+2 with the DUT idle; returns likewise
   task automatic access(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d);
      req   = 1'b1;
      we    = w;
      size  = sz;
      uns   = u;
      addr  = a;
      wdata = d;
      @(posedge clk_i); #2;
      req = 1'b0;
      @(posedge clk_i); #2;
   endtask

   initial begin
      int bad;
      logic [7:0] v;
      for (int i = 0; i < 65536; i++) begin
         v = 8'(i ^ (i >> 8) ^ 32'h5A);
         ref_mem[i]          = v;
         bank[i & 3][i >> 2] = v;
      end
      rst_ni = 1'b0;
      req    = 1'b1;
      we     = 1'b1;
      size   = 2'b10;
      uns    = 1'b0;
      addr   = 32'h0;
      wdata  = 32'hFFFFFFFF;
      repeat (3) @(posedge clk_i);
      #2;
      req    = 1'b0;
      rst_ni = 1'b1;
      @(posedge clk_i); #2;

      access(1'b1, 2'b10, 1'b0, 32'h0100, 32'hDEADBEEF);
      chk("b0_r40", {24'b0, bank[0][14'h40]}, 32'hEF);
      chk("b1_r40", {24'b0, bank[1][14'h40]}, 32'hBE);
      chk("b2_r40", {24'b0, bank[2][14'h40]}, 32'hAD);
      chk("b3_r40", {24'b0, bank[3][14'h40]}, 32'hDE);
      access(1'b0, 2'b10, 1'b0, 32'h0100, 32'h0);
      chk("lw_100", last_rdata, 32'hDEADBEEF);
      chk("lw_100_f", {31'b0, last_fault}, 32'h0);

      access(1'b1, 2'b00, 1'b0, 32'h0103, 32'h00000080);
      access(1'b0, 2'b00, 1'b0, 32'h0103, 32'h0);
      chk("lb_103", last_rdata, 32'hFFFFFF80);
      access(1'b0, 2'b00, 1'b1, 32'h0103, 32'h0);
      chk("lbu_103", last_rdata, 32'h00000080);
      access(1'b0, 2'b01, 1'b0, 32'h0102, 32'h0);
      chk("lh_102", last_rdata, 32'hFFFF80AD);
      access(1'b0, 2'b01, 1'b1, 32'h0103, 32'h0);
      chk("lhu_103", last_rdata, {16'h0, 8'(32'h04 ^ 32'h01 ^ 32'h5A), 8'h80});

      access(1'b1, 2'b10, 1'b0, 32'h0006, 32'h11223344);
      chk("b2_r1", {24'b0, bank[2][1]}, 32'h44);
      chk("b3_r1", {24'b0, bank[3][1]}, 32'h33);
      chk("b0_r2", {24'b0, bank[0][2]}, 32'h22);
      chk("b1_r2", {24'b0, bank[1][2]}, 32'h11);
      access(1'b0, 2'b10, 1'b0, 32'h0006, 32'h0);
      chk("lw_006", last_rdata, 32'h11223344);
      access(1'b1, 2'b01, 1'b0, 32'h0207, 32'hCAFEA55A);
      access(1'b0, 2'b01, 1'b1, 32'h0207, 32'h0);
      chk("lhu_207", last_rdata, 32'h0000A55A);
      access(1'b0, 2'b10, 1'b0, 32'hFFFC, 32'h0);

      access(1'b1, 2'b10, 1'b0, 32'hFFFE, 32'h12345678);
      chk("f_fffe", {31'b0, last_fault}, 32'h1);
      chk("f_fffe_d", last_rdata, 32'h0);
      access(1'b0, 2'b00, 1'b0, 32'h00010000, 32'h0);
      chk("f_10000", {31'b0, last_fault}, 32'h1);
      access(1'b1, 2'b11, 1'b0, 32'h0100, 32'h55555555);
      chk("f_sz11", {31'b0, last_fault}, 32'h1);
      access(1'b0, 2'b01, 1'b0, 32'hFFFE, 32'h0);
      chk("lh_fffe_ok", {31'b0, last_fault}, 32'h0);

      req  = 1'b1;
      we   = 1'b0;
      size = 2'b10;
      addr = 32'h0100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         rdy_seq[i] = ready;
      end
      chk("b2b_0", {31'b0, rdy_seq[0]}, 32'h1);
      chk("b2b_1", {31'b0, rdy_seq[1]}, 32'h0);
      chk("b2b_2", {31'b0, rdy_seq[2]}, 32'h1);
      chk("b2b_3", {31'b0, rdy_seq[3]}, 32'h0);
      @(posedge clk_i); #2;
      req = 1'b0;
      @(posedge clk_i); #2;

      req  = 1'b1;
      we   = 1'b0;
      size = 2'b10;
      addr = 32'h0100;
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      @(posedge clk_i); #3;
      rst_ni = 1'b1;
      req    = 1'b0;
      @(negedge clk_i);
      chk("rst_ready", {31'b0, ready}, 32'h1);
      chk("rst_norv", {31'b0, rvalid}, 32'h0);
      @(negedge clk_i);
      chk("rst_norv2", {31'b0, rvalid}, 32'h0);
      @(posedge clk_i); #2;

      req    = 1'b1;
      we     = 1'b1;
      size   = 2'b10;
      addr   = 32'h0300;
      wdata  = 32'h0BADF00D;
      rst_ni = 1'b0;
      @(negedge clk_i);
      chk("rst_st_wren", {28'b0, wren}, 32'h0);
      @(posedge clk_i); #3;
      rst_ni = 1'b1;
      req    = 1'b0;
      @(posedge clk_i); #2;
      access(1'b0, 2'b10, 1'b0, 32'h0300, 32'h0);
      chk("rst_st_nowr", {31'b0, last_rdata == 32'h0BADF00D}, 32'h0);

      bad = 0;
      for (int i = 0; i < 65536; i++)
         if (ref_mem[i] !== bank[i & 3][i >> 2]) bad++;
      chk("mem_image", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
